window_stream_packer: RTL and testbench

//  Parametrised successor to the HOG window serializer. Accepts one wide window plus metadata and emits

---
 rtl/window_stream_packer_pkg.sv | 21 ++
 rtl/window_stream_packer_if.sv | 29 ++
 rtl/window_pingpong_buf.sv | 61 ++++++
 rtl/window_stream_packer.sv | 78 +++++++
 tb/tb_window_stream_packer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_stream_packer_pkg.sv
// Shared sizing helpers for the HOG window stream packer and its
// classifier-side deserializer counterpart.
package window_stream_packer_pkg;

   // Integer ceiling division used to derive the beat count.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Payload bits carried per beat once metadata is prepended.
   function automatic int data_w(input int bus_w, input int meta_w);
      return bus_w - meta_w;
   endfunction

   // Beats needed to carry one window (guarded against a non-positive
   // DATA_W so the elaboration check can report the real problem).
   function automatic int num_beats(input int win_w, input int bus_w, input int meta_w);
      return ceil_div(win_w, (bus_w > meta_w) ? (bus_w - meta_w) : 1);
   endfunction

endpackage

// File: rtl/window_stream_packer_if.sv
// Window-in / beat-out bus of the window stream packer.
// master = upstream assembler plus downstream sink; slave = packer.
interface window_stream_packer_if #(
   parameter int WINDOW_WIDTH = 1152,
   parameter int BUS_WIDTH    = 128,
   parameter int META_WIDTH   = 4,
   parameter int IDX_WIDTH    = 4
);
   logic                    window_valid;
   logic                    window_ready;
   logic [WINDOW_WIDTH-1:0] window;
   logic [META_WIDTH-1:0]   metadata;
   logic                    stream_valid;
   logic                    stream_ready;
   logic [BUS_WIDTH-1:0]    stream;
   logic [IDX_WIDTH-1:0]    stream_idx;
   logic                    stream_first;
   logic                    stream_last;

   modport master (
      output window_valid, window, metadata, stream_ready,
      input  window_ready, stream_valid, stream, stream_idx, stream_first, stream_last
   );

   modport slave (
      input  window_valid, window, metadata, stream_ready,
      output window_ready, stream_valid, stream, stream_idx, stream_first, stream_last
   );
endinterface

// File: rtl/window_pingpong_buf.sv
// Two-entry ping-pong window buffer: one entry streams while the other
// loads. Ready/valid are pure functions of the registered occupancy.
module window_pingpong_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             rd_valid_o,
   input  logic             rd_pop_i,
   output logic [WIDTH-1:0] rd_data_o
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic             push, pop;

   assign wr_ready_o = (occ_q != 2'd2);
   assign rd_valid_o = (occ_q != 2'd0);
   assign push       = wr_valid_i && wr_ready_o;
   assign pop        = rd_pop_i && rd_valid_o;
   assign rd_data_o  = mem_q[rd_ptr_q];

   // Next pointers/occupancy; flush wins over any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         occ_d    = 2'd0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Payload storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end
endmodule

// File: rtl/window_stream_packer.sv
// Window stream packer: slices each buffered window into DATA_W-bit beats,
// prepends metadata, and tags beats with index and first/last flags.
module window_stream_packer
   import window_stream_packer_pkg::*;
#(
   parameter int WINDOW_WIDTH = 1152,
   parameter int BUS_WIDTH    = 128,
   parameter int META_WIDTH   = 4,
   parameter int IDX_WIDTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   window_stream_packer_if.slave bus
);
   localparam int DATA_W    = data_w(BUS_WIDTH, META_WIDTH);
   localparam int NUM_BEATS = num_beats(WINDOW_WIDTH, BUS_WIDTH, META_WIDTH);
   localparam int EXT_W     = NUM_BEATS * DATA_W;   // window zero-extended to whole beats
   localparam int SEL_W     = $clog2(EXT_W);
   localparam int ENTRY_W   = META_WIDTH + WINDOW_WIDTH;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BEATS - 1);

   if (META_WIDTH >= BUS_WIDTH) begin : g_bad_meta
      $error("window_stream_packer: META_WIDTH must be smaller than BUS_WIDTH");
   end
   if ((2 ** IDX_WIDTH) < NUM_BEATS) begin : g_bad_idx
      $error("window_stream_packer: IDX_WIDTH too narrow for NUM_BEATS");
   end

   logic [ENTRY_W-1:0]   rd_entry;
   logic                 rd_valid, fire, pop, is_last;
   logic [IDX_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [EXT_W-1:0]     win_ext;
   logic [SEL_W-1:0]     sel_base;
   logic [DATA_W-1:0]    slice;

   window_pingpong_buf #(.WIDTH(ENTRY_W)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .wr_valid_i (bus.window_valid),
      .wr_ready_o (bus.window_ready),
      .wr_data_i  ({bus.metadata, bus.window}),
      .rd_valid_o (rd_valid),
      .rd_pop_i   (pop),
      .rd_data_o  (rd_entry)
   );

   assign is_last = (beat_cnt_q == LAST_IDX);
   assign fire    = rd_valid && bus.stream_ready;
   assign pop     = fire && is_last;

   // Zero extension supplies the last-beat padding; the mux is a plain
   // indexed part-select so it scales with NUM_BEATS.
   assign win_ext  = EXT_W'(rd_entry[WINDOW_WIDTH-1:0]);
   assign sel_base = SEL_W'(int'(beat_cnt_q) * DATA_W);
   assign slice    = win_ext[sel_base +: DATA_W];

   // Beat counter next state: advance per handshake, wrap after last beat.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (fire) beat_cnt_d = is_last ? '0 : beat_cnt_q + 1'b1;
   end

   // Beat counter register; flush restarts the next window at beat 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     beat_cnt_q <= '0;
      else if (flush) beat_cnt_q <= '0;
      else            beat_cnt_q <= beat_cnt_d;
   end

   // All beat outputs are forced to zero while no window is buffered.
   assign bus.stream_valid = rd_valid;
   assign bus.stream       = rd_valid ? {rd_entry[ENTRY_W-1 -: META_WIDTH], slice} : '0;
   assign bus.stream_idx   = rd_valid ? beat_cnt_q : '0;
   assign bus.stream_first = rd_valid && (beat_cnt_q == '0);
   assign bus.stream_last  = rd_valid && is_last;
endmodule

// File: tb/tb_window_stream_packer.sv
// Self-checking bench for window_stream_packer: directed scenarios plus a
// randomized run checked against a queue-based window scoreboard.
module tb_window_stream_packer;
   localparam int WW = 1152;
   localparam int BW = 128;
   localparam int MW = 4;
   localparam int IW = 4;
   localparam int DW = BW - MW;
   localparam int NB = (WW + DW - 1) / DW;
   localparam int PW = NB * DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic flush_b = 1'b0;
   logic flush_c = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   window_stream_packer_if #(.WINDOW_WIDTH(WW), .BUS_WIDTH(BW), .META_WIDTH(MW), .IDX_WIDTH(IW)) bus ();
   window_stream_packer #(.WINDOW_WIDTH(WW), .BUS_WIDTH(BW), .META_WIDTH(MW), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

   // 64-bit bus, 120-bit window: two beats, last beat exactly full.
   window_stream_packer_if #(.WINDOW_WIDTH(120), .BUS_WIDTH(64), .META_WIDTH(4), .IDX_WIDTH(4)) bus_b ();
   window_stream_packer #(.WINDOW_WIDTH(120), .BUS_WIDTH(64), .META_WIDTH(4), .IDX_WIDTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b));

   // 128-bit bus, 120-bit window: single beat, first and last together.
   window_stream_packer_if #(.WINDOW_WIDTH(120), .BUS_WIDTH(128), .META_WIDTH(4), .IDX_WIDTH(1)) bus_c ();
   window_stream_packer #(.WINDOW_WIDTH(120), .BUS_WIDTH(128), .META_WIDTH(4), .IDX_WIDTH(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush(flush_c), .bus(bus_c));

   // Expected beat k of a window: metadata over the k-th DW-bit chunk,
   // zero above the window end.
   function automatic logic [BW-1:0] exp_beat(input logic [MW-1:0] m, input logic [WW-1:0] w, input int k);
      logic [WW-1:0] sh;
      sh = w >> (k * DW);
      return {m, sh[DW-1:0]};
   endfunction

   function automatic logic [WW-1:0] rand_win();
      logic [WW-1:0] w;
      for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic test_reset();
      #12;
      checks++;
      if (bus.stream_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", bus.stream_valid);
      end
      checks++;
      if (bus.window_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", bus.window_ready);
      end
      checks++;
      if (bus.stream !== '0 || bus.stream_idx !== '0 || bus.stream_first !== 1'b0 || bus.stream_last !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: stream=%h idx=%0d first=%b last=%b want all 0",
                            bus.stream, bus.stream_idx, bus.stream_first, bus.stream_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [WW-1:0] w;
      for (int i = 0; i < WW; i++) w[i] = (i % 2 == 1);
      @(negedge clk);
      bus.window = w; bus.metadata = 4'h5; bus.window_valid = 1'b1; bus.stream_ready = 1'b1;
      checks++;
      if (bus.window_ready !== 1'b1) begin
         errors++; $display("FAIL single_ready: got %b want 1", bus.window_ready);
      end
      @(negedge clk);
      bus.window_valid = 1'b0;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (bus.stream_valid !== 1'b1 || bus.stream_idx !== IW'(k) || bus.stream !== exp_beat(4'h5, w, k) ||
             bus.stream_first !== (k == 0) || bus.stream_last !== (k == NB - 1)) begin
            errors++;
            $display("FAIL single_beat%0d: valid=%b idx=%0d first=%b last=%b stream=%h want 1 %0d %b %b %h",
                     k, bus.stream_valid, bus.stream_idx, bus.stream_first, bus.stream_last, bus.stream,
                     k, (k == 0), (k == NB - 1), exp_beat(4'h5, w, k));
         end
         if (k == NB - 1) begin
            checks++;
            if (bus.stream[DW-1:WW-(NB-1)*DW] !== '0 || bus.stream[BW-1 -: MW] !== 4'h5) begin
               errors++; $display("FAIL single_pad: stream=%h want pad 0 and meta 5", bus.stream);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (bus.stream_valid !== 1'b0) begin
         errors++; $display("FAIL single_end: valid=%b want 0", bus.stream_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [WW-1:0] wins [3];
      int sent = 0, beats = 0, widx = 0, k = 0, cyc = 0;
      logic started = 1'b0, chk_ready = 1'b0;
      for (int i = 0; i < 3; i++) wins[i] = rand_win();
      bus.stream_ready = 1'b1;
      while (beats < 3 * NB && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (chk_ready) begin
            chk_ready = 1'b0;
            checks++;
            if (bus.window_ready !== 1'b0) begin
               errors++; $display("FAIL b2b_ready_drop: got %b want 0", bus.window_ready);
            end
         end
         if (bus.stream_valid === 1'b1 || started) begin
            started = 1'b1;
            checks++;
            if (bus.stream_valid !== 1'b1 || bus.stream_idx !== IW'(k) ||
                bus.stream !== exp_beat(MW'(widx + 1), wins[widx], k)) begin
               errors++;
               $display("FAIL b2b_beat%0d: valid=%b idx=%0d stream=%h want 1 %0d %h", beats,
                        bus.stream_valid, bus.stream_idx, bus.stream, k, exp_beat(MW'(widx + 1), wins[widx], k));
            end
            beats++;
            if (k == NB - 1) begin k = 0; widx++; end else k++;
         end
         bus.window_valid = (sent < 3);
         if (sent < 3) begin
            bus.window = wins[sent]; bus.metadata = MW'(sent + 1);
            if (bus.window_ready === 1'b1) begin
               sent++;
               if (sent == 2) chk_ready = 1'b1;
            end
         end
      end
      bus.window_valid = 1'b0;
      checks++;
      if (beats != 3 * NB) begin
         errors++; $display("FAIL b2b_timeout: beats=%0d want %0d", beats, 3 * NB);
      end
      @(negedge clk);
      checks++;
      if (bus.stream_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end: valid=%b want 0", bus.stream_valid);
      end
   endtask

   task automatic test_stall();
      logic [WW-1:0] w;
      logic [MW-1:0] m;
      int cyc = 0;
      w = rand_win(); m = MW'($urandom);
      @(negedge clk);
      bus.window = w; bus.metadata = m; bus.window_valid = 1'b1; bus.stream_ready = 1'b1;
      @(negedge clk);
      bus.window_valid = 1'b0;
      while (!(bus.stream_valid === 1'b1 && bus.stream_idx === IW'(NB - 1)) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc >= 50) begin
         errors++; $display("FAIL stall_reach_last: idx=%0d want %0d", bus.stream_idx, NB - 1);
      end
      bus.stream_ready = 1'b0;
      for (int s = 1; s <= 5; s++) begin
         @(negedge clk);
         checks++;
         if (bus.stream_valid !== 1'b1 || bus.stream_idx !== IW'(NB - 1) || bus.stream_last !== 1'b1 ||
             bus.stream !== exp_beat(m, w, NB - 1)) begin
            errors++;
            $display("FAIL stall_hold%0d: valid=%b idx=%0d stream=%h want 1 %0d %h", s,
                     bus.stream_valid, bus.stream_idx, bus.stream, NB - 1, exp_beat(m, w, NB - 1));
         end
         if (s == 5) bus.stream_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (bus.stream_valid !== 1'b0) begin
         errors++; $display("FAIL stall_retire: valid=%b want 0", bus.stream_valid);
      end
   endtask

   task automatic test_random();
      logic [WW-1:0] q_w [$];
      logic [MW-1:0] q_m [$];
      logic [PW-1:0] rec = '0;
      logic [WW-1:0] cur_w = '0;
      logic [MW-1:0] cur_m = '0;
      logic have = 1'b0, hold = 1'b0;
      logic [BW-1:0] prev_s = '0;
      logic [IW-1:0] prev_i = '0;
      int sent = 0, done = 0, k = 0, cyc = 0;
      while (done < 200 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (hold) begin
            checks++;
            if (bus.stream_valid !== 1'b1 || bus.stream !== prev_s || bus.stream_idx !== prev_i) begin
               errors++; $display("FAIL rand_hold: valid=%b idx=%0d stream=%h want 1 %0d %h",
                                  bus.stream_valid, bus.stream_idx, bus.stream, prev_i, prev_s);
            end
         end
         if (bus.stream_valid !== 1'b1) begin
            checks++;
            if (bus.stream !== '0 || bus.stream_idx !== '0 || bus.stream_first !== 1'b0 || bus.stream_last !== 1'b0) begin
               errors++; $display("FAIL rand_idle_zero: stream=%h idx=%0d want 0", bus.stream, bus.stream_idx);
            end
         end
         bus.stream_ready = ($urandom_range(0, 1) == 1);
         if (bus.stream_valid === 1'b1) begin
            checks++;
            if (q_m.size() == 0) begin
               errors++; $display("FAIL rand_spurious: beat idx=%0d with empty scoreboard", bus.stream_idx);
            end else begin
               if (bus.stream_idx !== IW'(k) || bus.stream_first !== (k == 0) || bus.stream_last !== (k == NB - 1) ||
                   bus.stream[BW-1 -: MW] !== q_m[0]) begin
                  errors++; $display("FAIL rand_tag: idx=%0d first=%b last=%b meta=%h want %0d %b %b %h",
                                     bus.stream_idx, bus.stream_first, bus.stream_last, bus.stream[BW-1 -: MW],
                                     k, (k == 0), (k == NB - 1), q_m[0]);
               end
               if (bus.stream_ready) begin
                  rec = rec | (PW'(bus.stream[DW-1:0]) << (k * DW));
                  if (k == NB - 1) begin
                     checks++;
                     if (rec !== PW'(q_w[0])) begin
                        errors++; $display("FAIL rand_window%0d: low64 got %h want %h", done, rec[63:0], q_w[0][63:0]);
                     end
                     void'(q_w.pop_front()); void'(q_m.pop_front());
                     rec = '0; k = 0; done++;
                  end else k++;
               end
            end
         end
         hold = (bus.stream_valid === 1'b1) && !bus.stream_ready;
         prev_s = bus.stream; prev_i = bus.stream_idx;
         if (!have && sent < 200 && $urandom_range(0, 3) != 0) begin
            cur_w = rand_win(); cur_m = MW'($urandom); have = 1'b1;
         end
         bus.window_valid = have; bus.window = cur_w; bus.metadata = cur_m;
         if (have && bus.window_ready === 1'b1) begin
            q_w.push_back(cur_w); q_m.push_back(cur_m);
            have = 1'b0; sent++;
         end
      end
      @(negedge clk);
      bus.window_valid = 1'b0; bus.stream_ready = 1'b1;
      checks++;
      if (done != 200) begin
         errors++; $display("FAIL rand_timeout: windows=%0d want 200", done);
      end
   endtask

   task automatic test_flush();
      logic [WW-1:0] wd;
      int cyc = 0;
      wd = rand_win();
      @(negedge clk);
      bus.window = rand_win(); bus.metadata = 4'h1; bus.window_valid = 1'b1; bus.stream_ready = 1'b1;
      @(negedge clk);
      bus.window = rand_win(); bus.metadata = 4'h2;
      @(negedge clk);
      bus.window_valid = 1'b0;
      while (!(bus.stream_valid === 1'b1 && bus.stream_idx === IW'(4)) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc >= 50 || bus.window_ready !== 1'b0) begin
         errors++; $display("FAIL flush_setup: idx=%0d ready=%b want 4 0", bus.stream_idx, bus.window_ready);
      end
      flush = 1'b1;
      bus.window = rand_win(); bus.metadata = 4'h7; bus.window_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (bus.stream_valid !== 1'b0 || bus.window_ready !== 1'b1) begin
         errors++; $display("FAIL flush_clear: valid=%b ready=%b want 0 1", bus.stream_valid, bus.window_ready);
      end
      bus.window = wd; bus.metadata = 4'h9; bus.window_valid = 1'b1;
      @(negedge clk);
      bus.window_valid = 1'b0;
      checks++;
      if (bus.stream_valid !== 1'b1 || bus.stream_idx !== '0 || bus.stream_first !== 1'b1 ||
          bus.stream !== exp_beat(4'h9, wd, 0)) begin
         errors++; $display("FAIL flush_restart: valid=%b idx=%0d stream=%h want 1 0 %h",
                            bus.stream_valid, bus.stream_idx, bus.stream, exp_beat(4'h9, wd, 0));
      end
      cyc = 0;
      while (bus.stream_valid === 1'b1 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != NB) begin
         errors++; $display("FAIL flush_drain: beats=%0d want %0d", cyc, NB);
      end
   endtask

   task automatic test_sweep();
      logic [127:0] t;
      logic [119:0] w;
      logic [119:0] w2;
      logic [3:0]   m;
      t = {$urandom, $urandom, $urandom, $urandom}; w = t[119:0];
      t = {$urandom, $urandom, $urandom, $urandom}; w2 = t[119:0];
      m = 4'($urandom);
      @(negedge clk);
      bus_b.window = w; bus_b.metadata = m; bus_b.window_valid = 1'b1; bus_b.stream_ready = 1'b1;
      @(negedge clk);
      bus_b.window_valid = 1'b0;
      checks++;
      if (bus_b.stream_valid !== 1'b1 || bus_b.stream_idx !== 4'd0 || bus_b.stream_first !== 1'b1 ||
          bus_b.stream_last !== 1'b0 || bus_b.stream !== {m, w[59:0]}) begin
         errors++; $display("FAIL sweep64_beat0: valid=%b idx=%0d f=%b l=%b stream=%h want %h",
                            bus_b.stream_valid, bus_b.stream_idx, bus_b.stream_first, bus_b.stream_last,
                            bus_b.stream, {m, w[59:0]});
      end
      @(negedge clk);
      checks++;
      if (bus_b.stream_valid !== 1'b1 || bus_b.stream_idx !== 4'd1 || bus_b.stream_first !== 1'b0 ||
          bus_b.stream_last !== 1'b1 || bus_b.stream !== {m, w[119:60]}) begin
         errors++; $display("FAIL sweep64_beat1: valid=%b idx=%0d f=%b l=%b stream=%h want %h",
                            bus_b.stream_valid, bus_b.stream_idx, bus_b.stream_first, bus_b.stream_last,
                            bus_b.stream, {m, w[119:60]});
      end
      @(negedge clk);
      checks++;
      if (bus_b.stream_valid !== 1'b0) begin
         errors++; $display("FAIL sweep64_end: valid=%b want 0", bus_b.stream_valid);
      end
      bus_c.window = w; bus_c.metadata = m; bus_c.window_valid = 1'b1; bus_c.stream_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_c.stream_valid !== 1'b1 || bus_c.stream_first !== 1'b1 || bus_c.stream_last !== 1'b1 ||
          bus_c.stream_idx !== 1'b0 || bus_c.stream !== {m, 4'h0, w}) begin
         errors++; $display("FAIL sweep1_beat_a: valid=%b f=%b l=%b stream=%h want %h", bus_c.stream_valid,
                            bus_c.stream_first, bus_c.stream_last, bus_c.stream, {m, 4'h0, w});
      end
      checks++;
      if (bus_c.window_ready !== 1'b1) begin
         errors++; $display("FAIL sweep1_ready: got %b want 1", bus_c.window_ready);
      end
      bus_c.window = w2; bus_c.metadata = ~m;
      @(negedge clk);
      bus_c.window_valid = 1'b0;
      checks++;
      if (bus_c.stream_valid !== 1'b1 || bus_c.stream_first !== 1'b1 || bus_c.stream_last !== 1'b1 ||
          bus_c.stream !== {~m, 4'h0, w2}) begin
         errors++; $display("FAIL sweep1_beat_b: valid=%b stream=%h want %h", bus_c.stream_valid,
                            bus_c.stream, {~m, 4'h0, w2});
      end
      @(negedge clk);
      checks++;
      if (bus_c.stream_valid !== 1'b0) begin
         errors++; $display("FAIL sweep1_end: valid=%b want 0", bus_c.stream_valid);
      end
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      @(negedge clk);
      bus.window = rand_win(); bus.metadata = 4'hA; bus.window_valid = 1'b1; bus.stream_ready = 1'b1;
      @(negedge clk);
      bus.window_valid = 1'b0;
      while (!(bus.stream_valid === 1'b1 && bus.stream_idx === IW'(6)) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc >= 50) begin
         errors++; $display("FAIL rstmid_reach: idx=%0d want 6", bus.stream_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.stream_valid !== 1'b0 || bus.window_ready !== 1'b1 || bus.stream !== '0 ||
          bus.stream_idx !== '0 || bus.stream_first !== 1'b0 || bus.stream_last !== 1'b0) begin
         errors++; $display("FAIL rstmid_async: valid=%b ready=%b idx=%0d stream=%h want 0 1 0 0",
                            bus.stream_valid, bus.window_ready, bus.stream_idx, bus.stream);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (bus.stream_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_beat: cycle %0d valid=%b idx=%0d want 0", i,
                               bus.stream_valid, bus.stream_idx);
         end
      end
   endtask

   initial begin
      bus.window_valid = 1'b0; bus.window = '0; bus.metadata = '0; bus.stream_ready = 1'b0;
      bus_b.window_valid = 1'b0; bus_b.window = '0; bus_b.metadata = '0; bus_b.stream_ready = 1'b0;
      bus_c.window_valid = 1'b0; bus_c.window = '0; bus_c.metadata = '0; bus_c.stream_ready = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_random();
      test_flush();
      test_sweep();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
